// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture FSM state encoding, also decoded
// by the host-register block.
package la_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRE       = 3'd1;
    localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
    localparam logic [2:0] ST_POST      = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_PRE       = ST_PRE,
        S_WAIT_TRIG = ST_WAIT_TRIG,
        S_POST      = ST_POST,
        S_DONE      = ST_DONE
    } cap_state_t;

endpackage

// File: rtl/capture_controller_if.sv
// Sample-buffer write port driven by the capture controller.
interface capture_controller_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/trigger_matcher.sv
// Combinational trigger match: masked level compare, plus an edge term when
// TRIG_EDGE_EN is defined.
module trigger_matcher #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
`ifdef TRIG_EDGE_EN
    input  logic [DATA_WIDTH-1:0] prev_sample,
    input  logic [DATA_WIDTH-1:0] trig_edge_mask,
`endif
    output logic                  hit
);

    logic [DATA_WIDTH-1:0] bit_ok;

    // A bit passes when it is don't-care or matches, and (edge build) toggled if edge-selected.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
`ifdef TRIG_EDGE_EN
            assign bit_ok[gi] = ~((data_in[gi] ^ trig_value[gi]) & trig_mask[gi])
                              & (~trig_edge_mask[gi] | (data_in[gi] ^ prev_sample[gi]));
`else
            assign bit_ok[gi] = ~((data_in[gi] ^ trig_value[gi]) & trig_mask[gi]);
`endif
        end
    endgenerate

    assign hit = &bit_ok;

endmodule

// File: rtl/capture_controller.sv
// Logic-analyzer capture FSM: pre-trigger fill, trigger wait, post-trigger fill
// into a circular sample buffer. Optional edge trigger under TRIG_EDGE_EN.
module capture_controller
    import la_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [ADDR_WIDTH-1:0] pretrig_len,
`ifdef TRIG_EDGE_EN
    input  logic [DATA_WIDTH-1:0] trig_edge_mask,
`endif
    capture_controller_if.master  buf_if,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state
);

    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    cap_state_t            state_reg;
    logic [ADDR_WIDTH-1:0] ptr_reg;
    logic [ADDR_WIDTH-1:0] pre_len_reg;
    logic [ADDR_WIDTH-1:0] pre_cnt_reg;
    logic [ADDR_WIDTH-1:0] post_cnt_reg;
    logic [ADDR_WIDTH-1:0] trig_addr_reg;
    logic                  wr_en_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_reg;
    logic [DATA_WIDTH-1:0] wr_data_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  trig_hit;
    logic                  arm_accept;
    logic                  capture_write;

    assign arm_accept    = arm && !abort && (state_reg == S_IDLE || state_reg == S_DONE);
    // busy_reg is high exactly in PRE, WAIT_TRIG and POST
    assign capture_write = sample_en && !abort && busy_reg;

`ifdef TRIG_EDGE_EN
    logic [DATA_WIDTH-1:0] prev_sample_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sample_reg <= '0;
        end else if (arm_accept) begin
            prev_sample_reg <= '0;
        end else if (sample_en) begin
            prev_sample_reg <= data_in;
        end
    end
`endif

    trigger_matcher #(
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_trigger_matcher (
        .data_in        (data_in),
        .trig_mask      (trig_mask),
        .trig_value     (trig_value),
`ifdef TRIG_EDGE_EN
        .prev_sample    (prev_sample_reg),
        .trig_edge_mask (trig_edge_mask),
`endif
        .hit            (trig_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            ptr_reg       <= '0;
            pre_len_reg   <= '0;
            pre_cnt_reg   <= '0;
            post_cnt_reg  <= '0;
            trig_addr_reg <= '0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            if (capture_write) begin
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= ptr_reg;
                wr_data_reg <= data_in;
                ptr_reg     <= ptr_reg + CNT_ONE;
            end

            if (abort) begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            pre_len_reg <= pretrig_len;
                            pre_cnt_reg <= pretrig_len;
                            ptr_reg     <= '0;
                            wr_addr_reg <= '0;
                            busy_reg    <= 1'b1;
                            done_reg    <= 1'b0;
                            if (pretrig_len == '0) begin
                                state_reg <= S_WAIT_TRIG;
                            end else begin
                                state_reg <= S_PRE;
                            end
                        end
                    end
                    S_PRE: begin
                        if (sample_en) begin
                            pre_cnt_reg <= pre_cnt_reg - CNT_ONE;
                            if (pre_cnt_reg == CNT_ONE) begin
                                state_reg <= S_WAIT_TRIG;
                            end
                        end
                    end
                    S_WAIT_TRIG: begin
                        if (sample_en && trig_hit) begin
                            trig_addr_reg <= ptr_reg;
                            // DEPTH-1-pretrig_len is the bitwise complement at this width
                            post_cnt_reg  <= ~pre_len_reg;
                            if (&pre_len_reg) begin
                                state_reg <= S_DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (sample_en) begin
                            post_cnt_reg <= post_cnt_reg - CNT_ONE;
                            if (post_cnt_reg == CNT_ONE) begin
                                state_reg <= S_DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign buf_if.wr_en   = wr_en_reg;
    assign buf_if.wr_addr = wr_addr_reg;
    assign buf_if.wr_data = wr_data_reg;
    assign trig_addr      = trig_addr_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign state          = state_reg;

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller (ADDR_WIDTH=4, DATA_WIDTH=8); the edge
// trigger step is built only with TRIG_EDGE_EN.
module tb_capture_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic       abort = 1'b0;
    logic       sample_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] trig_mask = 8'h00;
    logic [7:0] trig_value = 8'h00;
    logic [3:0] pretrig_len = 4'd0;
`ifdef TRIG_EDGE_EN
    logic [7:0] trig_edge_mask = 8'h00;
`endif
    logic [3:0] trig_addr;
    logic       busy;
    logic       done;
    logic [2:0] state;

    int         errors = 0;
    int         checks = 0;
    int         nwr;
    logic [7:0] seq [0:63];

    capture_controller_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) buf_if ();

    capture_controller #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .arm            (arm),
        .abort          (abort),
        .sample_en      (sample_en),
        .data_in        (data_in),
        .trig_mask      (trig_mask),
        .trig_value     (trig_value),
        .pretrig_len    (pretrig_len),
`ifdef TRIG_EDGE_EN
        .trig_edge_mask (trig_edge_mask),
`endif
        .buf_if         (buf_if),
        .trig_addr      (trig_addr),
        .busy           (busy),
        .done           (done),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic arm_pulse(input logic [3:0] pl, input logic [2:0] exp_state);
        pretrig_len = pl;
        sample_en   = 1'b0;
        arm         = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        check("arm_state", 32'(state), 32'(exp_state));
        check("arm_wr_addr", 32'(buf_if.wr_addr), 32'd0);
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_done", 32'(done), 32'd0);
    endtask

    // Sample k is presented in loop cycle k and must be written on the next edge at address k mod 16.
    task automatic run_capture(input int budget, input bit expect_done, output int n);
        int k;
        n = 0;
        k = 0;
        sample_en = 1'b1;
        data_in   = seq[0];
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            check("wr_en", 32'(buf_if.wr_en), 32'd1);
            if (buf_if.wr_en) begin
                check("wr_addr", 32'(buf_if.wr_addr), 32'(n % 16));
                check("wr_data", 32'(buf_if.wr_data), 32'(seq[n]));
                $display("write %0d: addr=%0d data=%02h state=%0d", n, buf_if.wr_addr, buf_if.wr_data, state);
                n++;
            end
            k++;
            data_in = seq[k];
            if (done) break;
        end
        if (expect_done) check("done_in_budget", 32'(done), 32'd1);
    endtask

    task automatic check_finished(input string tag, input int n, input int exp_n, input logic [3:0] exp_trig);
        check({tag, "_writes"}, 32'(n), 32'(exp_n));
        check({tag, "_trig_addr"}, 32'(trig_addr), 32'(exp_trig));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_state"}, 32'(state), 32'd4);
        @(posedge clk); #1;
        check({tag, "_no_write_in_done"}, 32'(buf_if.wr_en), 32'd0);
    endtask

    initial begin
        // Reset state before any clock edge
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_wr_en", 32'(buf_if.wr_en), 32'd0);
        check("rst_wr_addr", 32'(buf_if.wr_addr), 32'd0);
        check("rst_wr_data", 32'(buf_if.wr_data), 32'd0);
        check("rst_trig_addr", 32'(trig_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic capture: 4 pre + 7 wait (A5 at sample 10) + 11 post = 22 writes
        trig_mask  = 8'hFF;
        trig_value = 8'hA5;
        for (int i = 0; i < 64; i++) seq[i] = 8'(i);
        seq[10] = 8'hA5;
        arm_pulse(4'd4, 3'd1);
        run_capture(40, 1'b1, nwr);
        check_finished("basic", nwr, 22, 4'd10);

        // A5 during PRE is ignored; next A5 at sample 9 triggers: 10 + 11 = 21 writes
        for (int i = 0; i < 64; i++) seq[i] = 8'(8'h10 + i);
        seq[2] = 8'hA5;
        seq[9] = 8'hA5;
        arm_pulse(4'd4, 3'd1);
        run_capture(40, 1'b1, nwr);
        check_finished("pre_ignore", nwr, 21, 4'd9);

        // pretrig_len=15: trigger at sample 15 leaves zero post samples
        for (int i = 0; i < 64; i++) seq[i] = 8'(8'h10 + i);
        seq[3]  = 8'hA5;
        seq[15] = 8'hA5;
        arm_pulse(4'd15, 3'd1);
        run_capture(40, 1'b1, nwr);
        check_finished("pre15", nwr, 16, 4'd15);

        // pretrig_len=0: straight to WAIT_TRIG, trigger at sample 3 -> 4 + 15 = 19 writes
        for (int i = 0; i < 64; i++) seq[i] = 8'(8'h10 + i);
        seq[3] = 8'hA5;
        arm_pulse(4'd0, 3'd2);
        run_capture(40, 1'b1, nwr);
        check_finished("pre0", nwr, 19, 4'd3);

        // mask=00: first WAIT_TRIG sample (sample 2) triggers -> 3 + 13 = 16 writes
        trig_mask = 8'h00;
        for (int i = 0; i < 64; i++) seq[i] = 8'(8'h10 + i);
        arm_pulse(4'd2, 3'd1);
        run_capture(40, 1'b1, nwr);
        check_finished("mask0", nwr, 16, 4'd2);

        // Abort together with arm during POST
        trig_mask = 8'hFF;
        for (int i = 0; i < 64; i++) seq[i] = 8'(8'h10 + i);
        seq[1] = 8'hA5;
        arm_pulse(4'd0, 3'd2);
        run_capture(5, 1'b0, nwr);
        check("abort_pre_writes", 32'(nwr), 32'd5);
        check("abort_pre_state", 32'(state), 32'd3);
        abort = 1'b1;
        arm   = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        arm   = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_wr_en", 32'(buf_if.wr_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_idle_wr_en", 32'(buf_if.wr_en), 32'd0);
            check("abort_idle_state", 32'(state), 32'd0);
        end

`ifdef TRIG_EDGE_EN
        // Rising edge on bit 0 at the third sample only -> 3 + 15 = 18 writes
        trig_mask      = 8'h00;
        trig_edge_mask = 8'h01;
        for (int i = 0; i < 64; i++) seq[i] = 8'h00;
        seq[2] = 8'h01;
        arm_pulse(4'd0, 3'd2);
        run_capture(40, 1'b1, nwr);
        check_finished("edge", nwr, 18, 4'd2);
        trig_edge_mask = 8'h00;
        trig_mask      = 8'hFF;
`endif

        // Asynchronous reset in the middle of POST
        for (int i = 0; i < 64; i++) seq[i] = 8'(8'h10 + i);
        seq[2] = 8'hA5;
        arm_pulse(4'd0, 3'd2);
        run_capture(4, 1'b0, nwr);
        check("mid_post_state", 32'(state), 32'd3);
        check("mid_post_trig_addr", 32'(trig_addr), 32'd2);
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_wr_en", 32'(buf_if.wr_en), 32'd0);
        check("arst_wr_addr", 32'(buf_if.wr_addr), 32'd0);
        check("arst_wr_data", 32'(buf_if.wr_data), 32'd0);
        check("arst_trig_addr", 32'(trig_addr), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_release_wr_en", 32'(buf_if.wr_en), 32'd0);
        check("post_release_state", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/capture_controller.md
CAPTURE_CONTROLLER -- requirements
Module: capture_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the sample width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, giving the buffer address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port arm, input, 1 bit: start-capture pulse.
REQ-006 The block SHALL have port abort, input, 1 bit: cancel the capture and return to IDLE.
REQ-007 The block SHALL have port sample_en, input, 1 bit: sample-rate tick.
REQ-008 The block SHALL have port data_in, input, DATA_WIDTH bits: already-synchronized probe data.
REQ-009 The block SHALL have ports trig_mask and trig_value, input, DATA_WIDTH bits each: level-trigger pattern.
REQ-010 The block SHALL have port pretrig_len, input, ADDR_WIDTH bits: number of pre-trigger samples.
REQ-011 The block SHALL have ports wr_en (1), wr_addr (ADDR_WIDTH) and wr_data (DATA_WIDTH), outputs: sample-buffer write port.
REQ-012 The block SHALL have port trig_addr, output, ADDR_WIDTH bits: buffer address of the trigger sample.
REQ-013 The block SHALL have ports busy and done, outputs, 1 bit each: status.
REQ-014 The block SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-015 The FSM SHALL have states IDLE=0, PRE=1, WAIT_TRIG=2, POST=3 and DONE=4.
REQ-016 arm in IDLE or DONE SHALL latch pretrig_len, clear wr_addr to 0, and enter PRE, or WAIT_TRIG when pretrig_len==0; arm is ignored in any other state.
REQ-017 In PRE, WAIT_TRIG and POST, each sample_en cycle SHALL produce exactly one write on the next cycle: wr_en=1, wr_data=data_in, wr_addr=current pointer.
REQ-018 The write pointer SHALL then increment modulo DEPTH; wrap-around is silent.
REQ-019 PRE SHALL count latched pretrig_len writes, ignore the trigger, then enter WAIT_TRIG.
REQ-020 In WAIT_TRIG, the trigger SHALL hit when ((data_in ^ trig_value) & trig_mask)==0 on a sample_en cycle; trig_mask==0 SHALL trigger on the first sample.
REQ-021 On a trigger hit, the trigger sample SHALL be written, trig_addr SHALL be set to its address, the post counter SHALL be loaded with DEPTH-1-pretrig_len, and the FSM SHALL enter POST, or DONE if that value is 0.
REQ-022 POST SHALL decrement on each write and enter DONE after the write that takes the counter to 0.
REQ-023 busy SHALL be 1 in PRE, WAIT_TRIG and POST; done SHALL be 1 in DONE only; wr_en SHALL be 0 outside the write cycles of REQ-017.
REQ-024 abort SHALL send any state to IDLE on the next clock, and the pending write of that cycle SHALL be suppressed.
REQ-025 When arm and abort are asserted in the same cycle, abort SHALL win.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE and set wr_en, wr_addr, wr_data, trig_addr, busy, done and all counters to 0.
REQ-028 Reset mid-capture SHALL discard the capture; no write SHALL occur in the first cycle after release.

Configuration
REQ-029 With TRIG_EDGE_EN defined, the block SHALL add input trig_edge_mask (DATA_WIDTH bits) and a register holding the previous sample.
REQ-030 With TRIG_EDGE_EN defined, a trigger hit SHALL additionally require (data_in ^ prev_sample) & trig_edge_mask to equal trig_edge_mask.
REQ-031 With TRIG_EDGE_EN defined, prev_sample SHALL update on every sample_en and clear on arm.
REQ-032 Without TRIG_EDGE_EN, the block SHALL have no port or logic for edge triggering.

Structure
REQ-033 The state encoding localparams SHALL live in shared package la_pkg, reused by the host-register block.
REQ-034 The trigger-match logic SHALL be sub-module trigger_matcher, combinational, with the edge term under TRIG_EDGE_EN.
REQ-035 The FSM, counters and write port SHALL stay in capture_controller.

Verification (ADDR_WIDTH=4, DATA_WIDTH=8)
REQ-036 Reset: rst_n low mid-POST -> all outputs 0 and state=0 immediately; no wr_en in the cycle after release.
REQ-037 Basic capture: pretrig_len=4, mask=FF, value=A5, sample_en=1, data=0,1,..., A5 at sample 10 -> trig_addr=10, 22 writes total with addresses wrapping 15->0, done=1, busy=0.
REQ-038 Trigger in PRE: A5 at sample 2 with pretrig_len=4 -> ignored; capture stays in WAIT_TRIG until the next A5.
REQ-039 Boundaries: pretrig_len=15 -> DONE right after the trigger write; pretrig_len=0 -> PRE skipped; mask=00 -> trigger on the first WAIT_TRIG sample.
REQ-040 Abort: abort with arm in the same cycle during POST -> state=0 next cycle, no further wr_en, arm ignored.
REQ-041 Edge trigger (TRIG_EDGE_EN): edge_mask=01, mask=00, data 00,00,01 -> trigger on the third sample only.
